// File: rtl/alu_req_arbiter.sv
// Two-port arbiter in front of an in-order ALU; a tag FIFO routes each result back to its requester.
// Define ALU_ARB_FIXED_PRIORITY_EN to make port 0 win every tie instead of round-robin.
module alu_req_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic [4:0]               req0_opcode,
  input  logic [WIDTH-1:0]         req0_x,
  input  logic [WIDTH-1:0]         req0_y,
  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic [4:0]               req1_opcode,
  input  logic [WIDTH-1:0]         req1_x,
  input  logic [WIDTH-1:0]         req1_y,
  output logic                     alu_issue,
  output logic [4:0]               alu_opcode,
  output logic [WIDTH-1:0]         alu_x,
  output logic [WIDTH-1:0]         alu_y,
  input  logic                     alu_res_valid,
  input  logic [WIDTH-1:0]         alu_res,
  output logic                     rsp0_valid,
  output logic [WIDTH-1:0]         rsp0_data,
  output logic                     rsp1_valid,
  output logic [WIDTH-1:0]         rsp1_data,
  output logic [$clog2(DEPTH):0]   outstanding,
  output logic                     err
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic          full;
  logic          xfer;
  logic          sel;
  logic          pop;
  logic          head;
  logic          issue_id;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          tags [DEPTH];

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full = (outstanding == CW'(DEPTH));
  assign xfer = req0_ready | req1_ready;
  assign sel  = req1_ready;
  assign pop  = alu_res_valid && (count != '0);
  assign head = tags[rd_ptr];

`ifndef ALU_ARB_FIXED_PRIORITY_EN
  // Id of the most recent grantee; reset to 1 so port 0 wins the first tie.
  logic last_grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (xfer) begin
      last_grant <= sel;
    end
  end
`endif

  // Grant: single valid requester wins outright; ties resolved by priority mode.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (rst_n && !full) begin
      if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIORITY_EN
        req0_ready = 1'b1;
`else
        req0_ready = last_grant;
        req1_ready = !last_grant;
`endif
      end else begin
        req0_ready = req0_valid;
        req1_ready = req1_valid;
      end
    end
  end

  // Issue register: one-cycle pulse, payload holds between issues.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_issue  <= 1'b0;
      alu_opcode <= '0;
      alu_x      <= '0;
      alu_y      <= '0;
      issue_id   <= 1'b0;
    end else begin
      alu_issue <= xfer;
      if (xfer) begin
        alu_opcode <= sel ? req1_opcode : req0_opcode;
        alu_x      <= sel ? req1_x : req0_x;
        alu_y      <= sel ? req1_y : req0_y;
        issue_id   <= sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (alu_issue) begin
      tags[wr_ptr] <= issue_id;
    end
  end

  // Tag FIFO pointers; a pop only sees tags pushed on earlier edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (alu_issue) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      count <= count + CW'(alu_issue) - CW'(pop);
    end
  end

  // Result routing, outstanding count and sticky orphan-result flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp0_valid  <= 1'b0;
      rsp1_valid  <= 1'b0;
      rsp0_data   <= '0;
      rsp1_data   <= '0;
      outstanding <= '0;
      err         <= 1'b0;
    end else begin
      rsp0_valid <= pop && !head;
      rsp1_valid <= pop && head;
      if (pop && !head) begin
        rsp0_data <= alu_res;
      end
      if (pop && head) begin
        rsp1_data <= alu_res;
      end
      outstanding <= outstanding + CW'(xfer) - CW'(pop);
      if (alu_res_valid && !pop) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Randomized scoreboard bench for alu_req_arbiter: a queue-based reference model predicts grants,
// issues and routed results; a negedge monitor compares whatever the DUT presents.
module tb_alu_req_arbiter;

  localparam int unsigned W = 32;
  localparam int unsigned D = 4;

  typedef struct packed {
    logic [4:0]   op;
    logic [W-1:0] x;
    logic [W-1:0] y;
  } op_t;

  typedef struct packed {
    logic         id;
    logic [W-1:0] data;
  } rsp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [4:0]   req0_opcode, req1_opcode, alu_opcode;
  logic [W-1:0] req0_x, req0_y, req1_x, req1_y, alu_x, alu_y, alu_res;
  logic [W-1:0] rsp0_data, rsp1_data;
  logic         alu_issue, alu_res_valid, rsp0_valid, rsp1_valid, err;
  logic [$clog2(D):0] outstanding;

  alu_req_arbiter #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
    .req0_x(req0_x), .req0_y(req0_y),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
    .req1_x(req1_x), .req1_y(req1_y),
    .alu_issue(alu_issue), .alu_opcode(alu_opcode), .alu_x(alu_x), .alu_y(alu_y),
    .alu_res_valid(alu_res_valid), .alu_res(alu_res),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
    .outstanding(outstanding), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model state: plain queues of in-flight work plus a few scalars.
  op_t  issue_q[$];
  rsp_t rsp_q[$];
  bit   tags_q[$];
  int   m_out, m_last, dut_grant;
  bit   m_err, m_pend, m_pend_id;
  bit   exp_issue, exp_rsp0, exp_rsp1;
  logic [W-1:0] m_rsp0, m_rsp1;
  op_t  mon_o;
  rsp_t mon_r;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    issue_q.delete(); rsp_q.delete(); tags_q.delete();
    m_out = 0; m_last = 1; m_err = 0; m_pend = 0; m_pend_id = 0;
    exp_issue = 0; exp_rsp0 = 0; exp_rsp1 = 0;
    m_rsp0 = '0; m_rsp1 = '0;
  endtask

  // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
  task automatic cycle(input bit v0, input bit v1, input bit rv, input logic [W-1:0] res);
    int win;
    bit pop_ok, t;
    op_t o0, o1;
    o0.op = 5'($urandom); o0.x = $urandom; o0.y = $urandom;
    o1.op = 5'($urandom); o1.x = $urandom; o1.y = $urandom;
    req0_valid = v0; req0_opcode = o0.op; req0_x = o0.x; req0_y = o0.y;
    req1_valid = v1; req1_opcode = o1.op; req1_x = o1.x; req1_y = o1.y;
    alu_res_valid = rv; alu_res = res;
    #1;
    win = -1;
    if (m_out < int'(D)) begin
      if (v0 && v1) begin
`ifdef ALU_ARB_FIXED_PRIORITY_EN
        win = 0;
`else
        win = 1 - m_last;
`endif
      end else if (v0) win = 0;
      else if (v1) win = 1;
    end
    dut_grant = req1_ready ? 1 : (req0_ready ? 0 : -1);
    chk("req0_ready", 64'(req0_ready), 64'(win == 0));
    chk("req1_ready", 64'(req1_ready), 64'(win == 1));
    @(posedge clk);
    exp_rsp0 = 0; exp_rsp1 = 0; pop_ok = 0;
    if (rv && tags_q.size() > 0) begin
      t = tags_q.pop_front();
      pop_ok = 1;
      rsp_q.push_back('{id: t, data: res});
      if (t) begin exp_rsp1 = 1; m_rsp1 = res; end
      else begin exp_rsp0 = 1; m_rsp0 = res; end
    end else if (rv) begin
      m_err = 1;
    end
    if (m_pend) tags_q.push_back(m_pend_id);
    m_pend = (win >= 0);
    exp_issue = m_pend;
    if (win >= 0) begin
      m_pend_id = (win == 1);
      issue_q.push_back(win == 1 ? o1 : o0);
      m_last = win;
    end
    m_out = m_out + ((win >= 0) ? 1 : 0) - (pop_ok ? 1 : 0);
    #1;
  endtask

  // Asynchronous reset between edges; reset values must show up before any clock edge.
  task automatic reset_mid();
    #2;
    rst_n = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("rst_alu_issue", 64'(alu_issue), 64'(0));
    chk("rst_rsp0_valid", 64'(rsp0_valid), 64'(0));
    chk("rst_rsp1_valid", 64'(rsp1_valid), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_outstanding", 64'(outstanding), 64'(0));
    chk("rst_req0_ready", 64'(req0_ready), 64'(0));
    chk("rst_req1_ready", 64'(req1_ready), 64'(0));
    chk("rst_alu_x", 64'(alu_x), 64'(0));
    chk("rst_rsp0_data", 64'(rsp0_data), 64'(0));
    req0_valid = 1'b0; req1_valid = 1'b0; alu_res_valid = 1'b0;
    model_reset();
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Monitor: pops expectations whenever the DUT presents an issue or a response.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("alu_issue", 64'(alu_issue), 64'(exp_issue));
      if (alu_issue) begin
        chk("issue_q_nonempty", 64'(issue_q.size() != 0), 64'(1));
        if (issue_q.size() != 0) begin
          mon_o = issue_q.pop_front();
          chk("alu_opcode", 64'(alu_opcode), 64'(mon_o.op));
          chk("alu_x", 64'(alu_x), 64'(mon_o.x));
          chk("alu_y", 64'(alu_y), 64'(mon_o.y));
        end
      end
      chk("rsp0_valid", 64'(rsp0_valid), 64'(exp_rsp0));
      chk("rsp1_valid", 64'(rsp1_valid), 64'(exp_rsp1));
      if (rsp0_valid || rsp1_valid) begin
        chk("rsp_q_nonempty", 64'(rsp_q.size() != 0), 64'(1));
        if (rsp_q.size() != 0) begin
          mon_r = rsp_q.pop_front();
          chk("rsp_id", 64'(rsp1_valid), 64'(mon_r.id));
          chk("rsp_data", 64'(rsp1_valid ? rsp1_data : rsp0_data), 64'(mon_r.data));
        end
      end
      chk("rsp0_data_hold", 64'(rsp0_data), 64'(m_rsp0));
      chk("rsp1_data_hold", 64'(rsp1_data), 64'(m_rsp1));
      chk("outstanding", 64'(outstanding), 64'(m_out));
      chk("err", 64'(err), 64'(m_err));
    end
  end

  initial begin
    int nx;
    rst_n = 1'b0;
    req0_valid = 0; req1_valid = 0; alu_res_valid = 0;
    req0_opcode = '0; req1_opcode = '0;
    req0_x = '0; req0_y = '0; req1_x = '0; req1_y = '0; alu_res = '0;
    #1;
    reset_mid();

    // Tie on every cycle from a fresh reset: alternating grants, or port 0 only.
    for (int i = 0; i < 6; i++) begin
      cycle(1, 1, 1, $urandom);
`ifdef ALU_ARB_FIXED_PRIORITY_EN
      chk("tie_grant", 64'(dut_grant), 64'(0));
`else
      chk("tie_grant", 64'(dut_grant), 64'(i % 2));
`endif
    end

    // Silent ALU: exactly DEPTH transfers, then one retire frees one slot.
    reset_mid();
    nx = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1, 1, 0, '0);
      if (dut_grant >= 0) nx++;
    end
    chk("full_transfers", 64'(nx), 64'(D));
    chk("full_outstanding", 64'(outstanding), 64'(D));
    cycle(1, 1, 1, 32'h1234_5678);
    chk("full_no_grant_on_retire", 64'(dut_grant), 64'(-1));
    nx = 0;
    for (int i = 0; i < 3; i++) begin
      cycle(1, 1, 0, '0);
      if (dut_grant >= 0) nx++;
    end
    chk("full_refill", 64'(nx), 64'(1));

    // Reset with operations in flight, then a result arriving with nothing tracked.
    reset_mid();
    cycle(0, 0, 1, 32'hDEAD_BEEF);
    repeat (3) cycle(0, 0, 0, '0);
    chk("err_sticky", 64'(err), 64'(1));

    // Single op and in-order routing across ports.
    reset_mid();
    cycle(1, 0, 0, '0);
    cycle(0, 0, 0, '0);
    cycle(0, 0, 1, 32'h7);
    cycle(0, 0, 0, '0);
    cycle(1, 0, 0, '0);
    cycle(0, 1, 0, '0);
    cycle(1, 0, 0, '0);
    cycle(0, 0, 1, 32'hA);
    cycle(0, 0, 1, 32'hB);
    cycle(0, 0, 1, 32'hC);
    repeat (2) cycle(0, 0, 0, '0);
    chk("order_err_clear", 64'(err), 64'(0));

    // Random traffic.
    reset_mid();
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 60,
            $urandom_range(0, 99) < 45, $urandom);
    end
    repeat (10) cycle(0, 0, 1, $urandom);
    chk("drain_issue_q", 64'(issue_q.size()), 64'(0));
    chk("drain_rsp_q", 64'(rsp_q.size()), 64'(0));
    chk("drain_outstanding", 64'(outstanding), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_req_arbiter.md
ALU_REQ_ARBITER -- requirements
Module: alu_req_arbiter

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits.
REQ-002 Parameter: DEPTH, default 4, max outstanding ALU operations (tag FIFO depth, power of 2).
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 reqN_valid  input  1  (N=0,1) requester N presents an operation.
REQ-006 reqN_ready  output  1  operation from requester N accepted this cycle.
REQ-007 reqN_opcode  input  5  ALU opcode from requester N.
REQ-008 reqN_x, reqN_y  input  WIDTH each  operands from requester N.
REQ-009 alu_issue  output  1  one-cycle pulse, ALU operation valid.
REQ-010 alu_opcode  output  5; alu_x, alu_y  output  WIDTH  registered operation to ALU.
REQ-011 alu_res_valid  input  1; alu_res  input  WIDTH  ALU result, in issue order.
REQ-012 rspN_valid  output  1; rspN_data  output  WIDTH  (N=0,1) result returned to requester N.
REQ-013 outstanding  output  $clog2(DEPTH)+1  accepted, unretired operation count.
REQ-014 err  output  1  sticky: result arrived with no operation in flight.

Function
REQ-015 Transfer on requester N: reqN_valid && reqN_ready in the same cycle; at most one ready high per cycle.
REQ-016 Ready is combinational from reqN_valid, registered outstanding and last_grant; no ready to a non-valid requester.
REQ-017 Both readys SHALL be low when outstanding == DEPTH, even if a result retires that cycle.
REQ-018 Arbitration: one valid requester -> granted; both valid -> grant the one not equal to last_grant; last_grant updates on every transfer.
REQ-019 Accepted operation SHALL appear on alu_opcode/alu_x/alu_y with alu_issue=1 the cycle after transfer (latency 1); outputs hold last value while alu_issue=0.
REQ-020 On each alu_issue, push requester ID into the tag FIFO.
REQ-021 On alu_res_valid with FIFO non-empty: pop tag T; next cycle rspT_valid=1 for one cycle, rspT_data=alu_res; other rsp valid low.
REQ-022 rspN_data holds its last value when rspN_valid=0; responses have no backpressure.
REQ-023 outstanding increments on transfer, decrements on retire (pop); transfer and retire in same cycle leave it unchanged.
REQ-024 Issue-cycle push and same-cycle pop are both performed; FIFO pointers wrap modulo DEPTH.
REQ-025 alu_res_valid with FIFO empty (including the cycle an operation is only being issued): result dropped, no rsp, err set to 1 until reset.
REQ-026 Requester order preserved per port; results return in ALU issue order.

Reset
REQ-027 rst_n low SHALL immediately clear: alu_issue, rsp0_valid, rsp1_valid, err, outstanding, FIFO pointers to 0; alu_opcode/alu_x/alu_y/rspN_data to 0; last_grant to 1 (port 0 wins first tie).
REQ-028 Reset mid-operation discards all in-flight tags; results arriving after release with FIFO empty set err per REQ-025.
REQ-029 reqN_ready low while rst_n low.

Configuration
REQ-030 Macro ALU_ARB_FIXED_PRIORITY_EN: when defined, port 0 always wins ties (last_grant ignored); when undefined, round-robin per REQ-018.

Verification
REQ-031 Single op: req0 valid, opcode 5'b00001, x=32'h0000_0003, y=32'h0000_0004; ALU returns 32'h7 two cycles after issue -> alu_issue cycle+1, rsp0_valid one cycle later with 32'h7, outstanding 0->1->0.
REQ-032 Round-robin: both valid continuously for 6 transfers -> grants 0,1,0,1,0,1 (macro undefined); with ALU_ARB_FIXED_PRIORITY_EN -> 0,0,0,0,0,0.
REQ-033 Full: DEPTH=4, ALU never responds, both valid -> exactly 4 transfers, readys low thereafter, outstanding=4; one result -> one further transfer, rsp to first grantee.
REQ-034 Ordering: issue req0,req1,req0 with results 32'hA,32'hB,32'hC -> rsp0=A, rsp1=B, rsp0=C in that order.
REQ-035 Spurious result: alu_res_valid=1 after reset with no transfers -> no rsp pulse, err=1 and stays 1 until rst_n low.
REQ-036 Reset mid-flight: 3 outstanding, assert rst_n low asynchronously between edges -> all outputs at reset values immediately, outstanding 0.
